// File: rtl/stage_decode.sv
// Decode stage with the D/X pipeline register: field split, regfile read
// addressing, load-use bubble insertion and a saturating bubble counter.
module stage_decode #(
  parameter logic [4:0]  LW_OPCODE    = 5'b01000,
  parameter int unsigned BUBBLE_CNT_W = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             fd_instruction,
  input  logic [31:0]             fd_pc_plus_4,
  input  logic                    fd_valid,
  output logic [4:0]              ctrl_readRegA,
  output logic [4:0]              ctrl_readRegB,
  input  logic [31:0]             data_readRegA,
  input  logic [31:0]             data_readRegB,
  input  logic                    flush,
  input  logic                    stall_in,
  output logic                    stall_out,
  output logic [4:0]              dx_opcode,
  output logic [4:0]              dx_ALU_op,
  output logic [4:0]              dx_shamt,
  output logic [4:0]              dx_rd,
  output logic [16:0]             dx_immediate,
  output logic [26:0]             dx_target,
  output logic [31:0]             dx_operandA,
  output logic [31:0]             dx_operandB,
  output logic [31:0]             dx_pc_plus_4,
  output logic [4:0]              dx_pc_upper_5,
  output logic                    dx_valid,
  output logic [BUBBLE_CNT_W-1:0] bubble_count
);

  typedef enum logic [4:0] {
    OP_RTYPE = 5'b00000,
    OP_J     = 5'b00001,
    OP_BNE   = 5'b00010,
    OP_JAL   = 5'b00011,
    OP_JR    = 5'b00100,
    OP_BLT   = 5'b00110,
    OP_SW    = 5'b00111,
    OP_SETX  = 5'b10101,
    OP_BEX   = 5'b10110
  } opcode_e;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  alu_op;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic [16:0] immediate;
    logic [26:0] target;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] pc_plus_4;
    logic [4:0]  pc_upper_5;
    logic        valid;
  } dx_t;

  localparam logic [4:0] REG_BEX_STATUS = 5'd30;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic       use_a, use_b;
  logic       hz;

  dx_t                     dx_q, dx_d;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  assign fd_op = fd_instruction[31:27];
  assign fd_rd = fd_instruction[26:22];
  assign fd_rs = fd_instruction[21:17];
  assign fd_rt = fd_instruction[16:12];

  always_comb begin
    ctrl_readRegA = fd_rs;
    case (fd_op)
      OP_BNE, OP_BLT: ctrl_readRegA = fd_rd;
      OP_BEX:         ctrl_readRegA = REG_BEX_STATUS;
      default:        ctrl_readRegA = fd_rs;
    endcase
  end

  always_comb begin
    ctrl_readRegB = fd_rt;
    case (fd_op)
      OP_RTYPE:       ctrl_readRegB = fd_rt;
      OP_BNE, OP_BLT: ctrl_readRegB = fd_rs;
      OP_JR, OP_SW:   ctrl_readRegB = fd_rd;
      default:        ctrl_readRegB = fd_rt;
    endcase
  end

  // Port usage only gates hazard detection; the read addresses are always driven.
  always_comb begin
    use_a = 1'b1;
    use_b = 1'b0;
    case (fd_op)
      OP_J, OP_JAL, OP_SETX: use_a = 1'b0;
      default:               use_a = 1'b1;
    endcase
    case (fd_op)
      OP_RTYPE, OP_BNE, OP_BLT, OP_JR, OP_SW: use_b = 1'b1;
      default:                                use_b = 1'b0;
    endcase
  end

  assign hz = dx_q.valid & (dx_q.opcode == LW_OPCODE) & (dx_q.rd != 5'd0) & fd_valid &
              ((use_a & (ctrl_readRegA == dx_q.rd)) | (use_b & (ctrl_readRegB == dx_q.rd)));

  assign stall_out = hz & ~flush & ~stall_in;

  always_comb begin
    dx_d         = dx_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_in) begin
      dx_d = dx_q;
    end else if (flush) begin
      dx_d = '0;
    end else if (hz) begin
      dx_d = '0;
      if (bubble_cnt_q != '1) begin
        bubble_cnt_d = bubble_cnt_q + BUBBLE_CNT_W'(1);
      end
    end else if (fd_valid) begin
      dx_d.opcode     = fd_op;
      dx_d.alu_op     = fd_instruction[6:2];
      dx_d.shamt      = fd_instruction[11:7];
      dx_d.rd         = fd_rd;
      dx_d.immediate  = fd_instruction[16:0];
      dx_d.target     = fd_instruction[26:0];
      dx_d.operand_a  = data_readRegA;
      dx_d.operand_b  = data_readRegB;
      dx_d.pc_plus_4  = fd_pc_plus_4;
      dx_d.pc_upper_5 = fd_pc_plus_4[31:27];
      dx_d.valid      = 1'b1;
    end else begin
      dx_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dx_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      dx_q         <= dx_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign dx_opcode     = dx_q.opcode;
  assign dx_ALU_op     = dx_q.alu_op;
  assign dx_shamt      = dx_q.shamt;
  assign dx_rd         = dx_q.rd;
  assign dx_immediate  = dx_q.immediate;
  assign dx_target     = dx_q.target;
  assign dx_operandA   = dx_q.operand_a;
  assign dx_operandB   = dx_q.operand_b;
  assign dx_pc_plus_4  = dx_q.pc_plus_4;
  assign dx_pc_upper_5 = dx_q.pc_upper_5;
  assign dx_valid      = dx_q.valid;
  assign bubble_count  = bubble_cnt_q;

endmodule

// File: tb/tb_stage_decode.sv
// Bench for stage_decode: directed sequences plus randomized traffic checked
// every cycle against a behavioural model of the decode/D-X rules.
module tb_stage_decode;

  localparam int unsigned CW   = 2;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   fd_instruction = '0;
  logic [31:0]   fd_pc_plus_4 = '0;
  logic          fd_valid = 1'b0;
  logic [4:0]    ctrl_readRegA, ctrl_readRegB;
  logic [31:0]   data_readRegA, data_readRegB;
  logic          flush = 1'b0;
  logic          stall_in = 1'b0;
  logic          stall_out;
  logic [4:0]    dx_opcode, dx_ALU_op, dx_shamt, dx_rd, dx_pc_upper_5;
  logic [16:0]   dx_immediate;
  logic [26:0]   dx_target;
  logic [31:0]   dx_operandA, dx_operandB, dx_pc_plus_4;
  logic          dx_valid;
  logic [CW-1:0] bubble_count;

  logic [31:0] rf [32];

  stage_decode #(.LW_OPCODE(5'b01000), .BUBBLE_CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .fd_instruction(fd_instruction), .fd_pc_plus_4(fd_pc_plus_4), .fd_valid(fd_valid),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .flush(flush), .stall_in(stall_in), .stall_out(stall_out),
    .dx_opcode(dx_opcode), .dx_ALU_op(dx_ALU_op), .dx_shamt(dx_shamt), .dx_rd(dx_rd),
    .dx_immediate(dx_immediate), .dx_target(dx_target),
    .dx_operandA(dx_operandA), .dx_operandB(dx_operandB),
    .dx_pc_plus_4(dx_pc_plus_4), .dx_pc_upper_5(dx_pc_upper_5),
    .dx_valid(dx_valid), .bubble_count(bubble_count)
  );

  always #5 clock = ~clock;

  // Behavioural regfile: combinational read of whatever the DUT addresses.
  always_comb begin
    data_readRegA = rf[ctrl_readRegA];
    data_readRegB = rf[ctrl_readRegB];
  end

  typedef struct {
    bit          valid;
    int unsigned op, alu, shamt, rd, imm, tgt, a, b, pc, pcu, cnt;
  } mstate_t;

  mstate_t m, mn;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned f_op(input int unsigned w); return (w >> 27) & 31; endfunction
  function automatic int unsigned f_rd(input int unsigned w); return (w >> 22) & 31; endfunction
  function automatic int unsigned f_rs(input int unsigned w); return (w >> 17) & 31; endfunction
  function automatic int unsigned f_rt(input int unsigned w); return (w >> 12) & 31; endfunction

  function automatic int unsigned exp_ra(input int unsigned w);
    int unsigned op = f_op(w);
    if (op == 2 || op == 6) return f_rd(w);
    if (op == 22) return 30;
    return f_rs(w);
  endfunction

  function automatic int unsigned exp_rb(input int unsigned w);
    int unsigned op = f_op(w);
    if (op == 2 || op == 6) return f_rs(w);
    if (op == 4 || op == 7) return f_rd(w);
    return f_rt(w);
  endfunction

  function automatic bit uses_a(input int unsigned w);
    int unsigned op = f_op(w);
    return !(op == 1 || op == 3 || op == 21);
  endfunction

  function automatic bit uses_b(input int unsigned w);
    int unsigned op = f_op(w);
    return (op == 0 || op == 2 || op == 6 || op == 4 || op == 7);
  endfunction

  function automatic bit exp_hz();
    int unsigned w = fd_instruction;
    if (!(m.valid && m.op == 8 && m.rd != 0 && fd_valid)) return 0;
    return (uses_a(w) && exp_ra(w) == m.rd) || (uses_b(w) && exp_rb(w) == m.rd);
  endfunction

  function automatic mstate_t bubble(input int unsigned cnt);
    mstate_t z = '{default: 0};
    z.cnt = cnt;
    return z;
  endfunction

  function automatic logic [31:0] mk(input int unsigned op, rd, rs, low17);
    return 32'((op << 27) | (rd << 22) | (rs << 17) | (low17 & 32'h1ffff));
  endfunction

  task automatic check_regs();
    chk("dx_valid",      32'(dx_valid),      32'(m.valid));
    chk("dx_opcode",     32'(dx_opcode),     m.op);
    chk("dx_ALU_op",     32'(dx_ALU_op),     m.alu);
    chk("dx_shamt",      32'(dx_shamt),      m.shamt);
    chk("dx_rd",         32'(dx_rd),         m.rd);
    chk("dx_immediate",  32'(dx_immediate),  m.imm);
    chk("dx_target",     32'(dx_target),     m.tgt);
    chk("dx_operandA",   dx_operandA,        m.a);
    chk("dx_operandB",   dx_operandB,        m.b);
    chk("dx_pc_plus_4",  dx_pc_plus_4,       m.pc);
    chk("dx_pc_upper_5", 32'(dx_pc_upper_5), m.pcu);
    chk("bubble_count",  32'(bubble_count),  m.cnt);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input bit fv, input bit fl, input bit si);
    fd_instruction = ins;
    fd_pc_plus_4   = pc;
    fd_valid       = fv;
    flush          = fl;
    stall_in       = si;
    #1;
  endtask

  // Mid-cycle check of combinational outputs, model step, then post-edge check.
  task automatic tick();
    int unsigned w;
    bit          hz;
    @(negedge clock);
    w  = fd_instruction;
    hz = exp_hz();
    chk("ctrl_readRegA", 32'(ctrl_readRegA), exp_ra(w));
    chk("ctrl_readRegB", 32'(ctrl_readRegB), exp_rb(w));
    chk("stall_out",     32'(stall_out),     32'(hz && !flush && !stall_in));
    if (stall_in) begin
      mn = m;
    end else if (flush || hz) begin
      mn = bubble(m.cnt);
      if (!flush && m.cnt < CMAX) mn.cnt = m.cnt + 1;
    end else if (fd_valid) begin
      mn.valid = 1;
      mn.op    = f_op(w);
      mn.alu   = (w >> 2) & 31;
      mn.shamt = (w >> 7) & 31;
      mn.rd    = f_rd(w);
      mn.imm   = w & 32'h1ffff;
      mn.tgt   = w & 32'h7ffffff;
      mn.a     = rf[exp_ra(w)];
      mn.b     = rf[exp_rb(w)];
      mn.pc    = fd_pc_plus_4;
      mn.pcu   = fd_pc_plus_4 >> 27;
      mn.cnt   = m.cnt;
    end else begin
      mn = bubble(m.cnt);
    end
    @(posedge clock);
    #1;
    m = mn;
    check_regs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned ops [15] = '{0, 0, 8, 8, 8, 2, 6, 22, 4, 7, 1, 3, 21, 5, 9};
    int unsigned cnt_before;
    logic [31:0] lw4, add5, ins;

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    m = bubble(0);
    lw4  = mk(8, 4, 2, 16);
    add5 = mk(0, 5, 4, 1 << 12);

    // Reset state
    #2;
    chk("reset_dx_valid", 32'(dx_valid), 32'd0);
    chk("reset_stall_out", 32'(stall_out), 32'd0);
    check_regs();
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;

    // Plain decode: add $3,$1,$2
    drive(mk(0, 3, 1, 2 << 12), 32'h8000_0104, 1, 0, 0);
    chk("add_readA", 32'(ctrl_readRegA), 32'd1);
    chk("add_readB", 32'(ctrl_readRegB), 32'd2);
    tick();
    chk("add_opA", dx_operandA, 32'd5);
    chk("add_opB", dx_operandB, 32'd7);
    chk("add_rd", 32'(dx_rd), 32'd3);
    chk("add_valid", 32'(dx_valid), 32'd1);
    chk("add_pcu", 32'(dx_pc_upper_5), 32'd16);

    // Asynchronous reset mid-cycle with D/X loaded, release before next edge
    reset = 1'b0;
    #1;
    m = bubble(0);
    chk("async_valid", 32'(dx_valid), 32'd0);
    chk("async_rd", 32'(dx_rd), 32'd0);
    chk("async_opA", dx_operandA, 32'd0);
    check_regs();
    drive(mk(0, 3, 1, 2 << 12), 32'h104, 1, 0, 0);
    reset = 1'b1;
    #1;
    tick();
    chk("post_reset_valid", 32'(dx_valid), 32'd1);

    // Load-use: lw $4 then add $5,$4,$1
    drive(lw4, 32'h200, 1, 0, 0);
    tick();
    drive(add5, 32'h204, 1, 0, 0);
    chk("lu_stall", 32'(stall_out), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(dx_valid), 32'd0);
    chk("lu_count", 32'(bubble_count), 32'd1);
    chk("lu_stall_drop", 32'(stall_out), 32'd0);
    tick();
    chk("lu_add_rd", 32'(dx_rd), 32'd5);
    chk("lu_add_valid", 32'(dx_valid), 32'd1);

    // lw $0 never stalls
    drive(mk(8, 0, 2, 4), 32'h300, 1, 0, 0);
    tick();
    drive(mk(0, 5, 0, 0), 32'h304, 1, 0, 0);
    chk("lw0_no_stall", 32'(stall_out), 32'd0);
    tick();

    // bne $6,$7 reads and flush
    drive(mk(2, 6, 7, 12), 32'h400, 1, 1, 0);
    chk("bne_readA", 32'(ctrl_readRegA), 32'd6);
    chk("bne_readB", 32'(ctrl_readRegB), 32'd7);
    tick();
    chk("flush_valid", 32'(dx_valid), 32'd0);
    chk("flush_op", 32'(dx_opcode), 32'd0);

    // flush together with hazard: no stall, no count
    drive(lw4, 32'h500, 1, 0, 0);
    tick();
    cnt_before = bubble_count;
    drive(add5, 32'h504, 1, 1, 0);
    chk("flush_hz_stall", 32'(stall_out), 32'd0);
    tick();
    chk("flush_hz_count", 32'(bubble_count), cnt_before);

    // Hold for 3 cycles while F/D changes
    drive(mk(0, 3, 1, 2 << 12), 32'h600, 1, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(mk(0, 9 + i, 2, 1 << 12), 32'h700 + 4 * i, 1, (i == 1), 1);
      tick();
      chk("hold_rd", 32'(dx_rd), 32'd3);
    end
    drive(mk(0, 11, 2, 1 << 12), 32'h710, 1, 0, 0);
    tick();
    chk("release_rd", 32'(dx_rd), 32'd11);

    // Special read ports
    drive(mk(22, 0, 0, 100), 32'h800, 1, 0, 0);
    chk("bex_readA", 32'(ctrl_readRegA), 32'd30);
    tick();
    drive(mk(4, 9, 0, 0), 32'h804, 1, 0, 0);
    chk("jr_readB", 32'(ctrl_readRegB), 32'd9);
    tick();
    drive(mk(7, 9, 2, 4), 32'h808, 1, 0, 0);
    chk("sw_readB", 32'(ctrl_readRegB), 32'd9);
    tick();

    // Five more bubbles saturate the narrow counter
    for (int i = 0; i < 5; i++) begin
      drive(lw4, 32'h900, 1, 0, 0);
      tick();
      drive(add5, 32'h904, 1, 0, 0);
      tick();
      tick();
    end
    chk("sat_count", 32'(bubble_count), CMAX);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      ins = mk(ops[$urandom_range(0, 14)], $urandom_range(0, 7), $urandom_range(0, 7),
               ($urandom_range(0, 7) << 12) | ($urandom & 32'hfff));
      if ($urandom_range(0, 9) == 0) rf[$urandom_range(0, 31)] = $urandom;
      drive(ins, $urandom, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage_decode.md
# stage_decode

Decode stage and D/X pipeline register feeding `stage_execute`. It takes the fetched instruction and PC+4 from the F/D latch and splits out the instruction fields. It drives the regfile read addresses and registers the decoded fields plus both read operands for the execute stage. It also detects load-use hazards, inserts bubbles, and honours execute-stage redirects and downstream stalls.

## Interface
- `LW_OPCODE`, 5'b01000, opcode treated as a load for hazard detection
- `BUBBLE_CNT_W`, 16, width of the bubble performance counter
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low; clears all state immediately
- `fd_instruction` in 32: instruction from F/D latch
- `fd_pc_plus_4` in 32: PC+4 of that instruction
- `fd_valid` in 1: F/D holds a real instruction
- `ctrl_readRegA`, `ctrl_readRegB` out 5: regfile read addresses (combinational)
- `data_readRegA`, `data_readRegB` in 32: regfile read data, same cycle
- `flush` in 1: execute redirect (taken branch/j/jal/jr/bex); kill the instruction in decode
- `stall_in` in 1: downstream busy; hold D/X
- `stall_out` out 1: load-use stall; fetch must hold PC and F/D
- `dx_opcode`, `dx_ALU_op`, `dx_shamt`, `dx_rd` out 5 each
- `dx_immediate` out 17
- `dx_target` out 27
- `dx_operandA`, `dx_operandB` out 32: registered regfile data
- `dx_pc_plus_4` out 32
- `dx_pc_upper_5` out 5: `fd_pc_plus_4[31:27]`
- `dx_valid` out 1: D/X holds a real instruction
- `bubble_count` out `BUBBLE_CNT_W`: saturating count of load-use bubbles

## Operation
- Fields are opcode [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], ALU_op [6:2], immediate [16:0], target [26:0].
- `ctrl_readRegA`:
  - bne (00010), blt (00110): rd
  - bex (10110): 5'd30
  - all others: rs
- `ctrl_readRegB`:
  - R-type (00000): rt
  - bne, blt: rs
  - jr (00100), sw (00111): rd
  - all others: rt
- Read-usage flags for hazard checks:
  - A is used by every opcode except j (00001), jal (00011), setx (10101).
  - B is used only by R-type, bne, blt, jr, sw.
- ALU_op and shamt pass through raw. Execute interprets them only for R-type.
- Load-use hazard `hz` = `dx_valid & dx_opcode==LW_OPCODE & dx_rd!=0 & fd_valid & ((useA & ctrl_readRegA==dx_rd) | (useB & ctrl_readRegB==dx_rd))`.
- `stall_out = hz & ~flush & ~stall_in`. It is combinational.
- All other RAW cases are bypassed downstream. This block detects only load-use.
- D/X update on each rising edge, in priority order:
  1. `stall_in`: hold all dx_* and `bubble_count`.
  2. `flush`: bubble. Set `dx_valid`=0 and clear all dx_* fields to 0 (opcode 0 with rd 0 is a nop).
  3. `hz`: bubble as above, and increment `bubble_count`, saturating at all-ones.
  4. Otherwise load decoded fields and operands, with `dx_valid`=`fd_valid`. When `fd_valid`=0, all fields load as 0.
- Reset (async, low): every dx_* output = 0, `dx_valid`=0, `bubble_count`=0. `stall_out` is therefore 0 while in reset.
- Reset deasserting mid-stream: the first edge after release behaves as a normal edge.

## Timing
- Decode-to-execute latency: 1 cycle. An instruction presented on F/D with no hazard appears on dx_* after the next rising edge.
- Regfile is read combinationally in the same cycle. A write-back in that cycle is bypassed inside the regfile, not here.
- A load-use stall lasts exactly 1 cycle. The edge that inserts the bubble clears the lw-in-X condition, so `hz` drops next cycle (F/D is held, so the same instruction re-decodes).
- `flush` with `hz` in the same cycle: flush wins, no bubble is counted, and `stall_out`=0.
- `flush` with `stall_in` in the same cycle: hold wins. Execute keeps `flush` asserted until the stall clears.
- `bubble_count` increments only on edges where priority 3 applies.

## Test plan
- Reset: drive reset=0 mid-cycle with D/X loaded -> all dx_* = 0, `dx_valid`=0, `bubble_count`=0 immediately, with no clock edge needed.
- Plain decode: add $3,$1,$2 (rs=1, rt=2) with regfile values 5 and 7 -> `ctrl_readRegA`=1, `ctrl_readRegB`=2; next edge `dx_operandA`=5, `dx_operandB`=7, `dx_rd`=3, `dx_valid`=1.
- Load-use: lw $4 in D/X followed by add $5,$4,$1 in F/D -> `stall_out`=1 for one cycle, one bubble with `dx_valid`=0, `bubble_count` 0->1; the add reaches D/X on the following edge. Same sequence with lw $0 -> no stall.
- Branch operands and flush: bne $6,$7,N -> reads A=6, B=7. With `flush`=1 that edge -> `dx_valid`=0 and fields 0. With flush and hz together -> no count, `stall_out`=0.
- Hold: `stall_in`=1 for 3 cycles while F/D changes -> dx_* unchanged. After release the current F/D instruction loads.
- Special reads: bex -> `ctrl_readRegA`=30; jr $9 and sw $9,4($2) -> `ctrl_readRegB`=9. With `BUBBLE_CNT_W`=2, force 5 bubbles -> count saturates at 3.
